// File: rtl/ram_dumper.sv
// Streams a range of bytes from a synchronous RAM out through a valid/ready port.
// Define RAM_DUMPER_CHECKSUM_EN to append a two's-complement checksum byte to each dump.
module ram_dumper #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADDR_BITS-1:0] base_addr,
    input  logic [ADDR_BITS:0]   length,
    output logic                 mem_re,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic [7:0]           out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    // state | meaning
    // IDLE  | waiting for start
    // FETCH | mem_re high for the current address
    // WAIT  | RAM data arrives, captured into out_data
    // SEND  | out_valid high until out_ready
    // CSUM  | checksum byte presented (checksum builds only)
    // DONE  | last byte accepted; done pulses on the following cycle
`ifdef RAM_DUMPER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4,
        S_CSUM  = 3'd5
    } state_t;
    localparam state_t S_TAIL = S_CSUM;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4
    } state_t;
    localparam state_t S_TAIL = S_DONE;
`endif

    localparam logic [ADDR_BITS:0]   REM_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

    state_t               state;
    state_t               state_next;
    logic [ADDR_BITS-1:0] addr;
    logic [ADDR_BITS:0]   remaining;
    logic                 last_byte;

`ifdef RAM_DUMPER_CHECKSUM_EN
    logic [7:0] csum;
    logic [7:0] csum_next;
    logic [7:0] csum_byte;
    assign csum_next = csum + out_data;
    assign csum_byte = (~csum_next) + 8'd1;
`endif

    assign last_byte = (remaining == REM_ONE);
    assign mem_addr  = addr;

    always_comb begin
        state_next = state;
        mem_re     = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = (length != '0) ? S_FETCH : S_TAIL;
            end
            S_FETCH: begin
                mem_re     = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: state_next = S_SEND;
            S_SEND: begin
                out_valid = 1'b1;
                if (out_ready) state_next = last_byte ? S_TAIL : S_FETCH;
            end
`ifdef RAM_DUMPER_CHECKSUM_EN
            S_CSUM: begin
                out_valid = 1'b1;
                if (out_ready) state_next = S_DONE;
            end
`endif
            S_DONE: begin
                busy       = 1'b0;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            remaining <= '0;
            out_data  <= 8'd0;
            done      <= 1'b0;
`ifdef RAM_DUMPER_CHECKSUM_EN
            csum      <= 8'd0;
`endif
        end else begin
            state <= state_next;
            done  <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr      <= base_addr;
                        remaining <= length;
                        // A zero-length dump presents the checksum of nothing, i.e. 0x00.
                        out_data  <= 8'd0;
`ifdef RAM_DUMPER_CHECKSUM_EN
                        csum      <= 8'd0;
`endif
                    end
                end
                S_WAIT: out_data <= mem_rdata;
                S_SEND: begin
                    if (out_ready) begin
                        addr      <= addr + ADDR_ONE;
                        remaining <= remaining - REM_ONE;
`ifdef RAM_DUMPER_CHECKSUM_EN
                        csum      <= csum_next;
                        if (last_byte) out_data <= csum_byte;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
